// File: rtl/rc5_pkg.sv
// rtl/rc5_pkg.sv - shared FSM states, legal configuration constants and helpers for rc5_cipher
package rc5_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ROUND = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } rc5_state_e;

    // Supported word widths and round-count range.
    localparam int RC5_W_SMALL    = 8;
    localparam int RC5_W_MID      = 16;
    localparam int RC5_W_LARGE    = 32;
    localparam int RC5_ROUNDS_MIN = 1;
    localparam int RC5_ROUNDS_MAX = 20;

    // Number of low-order bits of a word that form a rotate distance.
    function automatic int rot_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// rtl/rc5_rotl.sv - variable rotate of one W-bit word, left or right
// Ports: x - word to rotate; amt - rotate distance; dir - 0 rotate left, 1 rotate right;
//        y - rotated word.
module rc5_rotl
    import rc5_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]              x,
    input  logic [rot_width(W)-1:0]   amt,
    input  logic                      dir,
    output logic [W-1:0]              y
);

    localparam int LG = rot_width(W);

    // Log-depth barrel: stage k rotates by 2**k when amt[k] is set.
    logic [W-1:0] stg [0:LG];

    assign stg[0] = x;

    for (genvar k = 0; k < LG; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [W-1:0] rl;
        logic [W-1:0] rr;
        assign rl         = {stg[k][W-1-SH:0], stg[k][W-1:W-SH]};
        assign rr         = {stg[k][SH-1:0],   stg[k][W-1:SH]};
        assign stg[k+1]   = amt[k] ? (dir ? rr : rl) : stg[k];
    end

    assign y = stg[LG];

endmodule

// File: rtl/rc5_cipher.sv
// rtl/rc5_cipher.sv - RC5 block cipher, one round per clock, loadable round-key table
// Ports: clock, reset (synchronous, active-high); start, mode, p request an operation
//        (mode 1 = decrypt); c, done, busy report it; key_we, key_addr, key_data write
//        round key S[key_addr] while idle.
// Build option: RC5_DEC_EN includes the decrypt path; without it mode is ignored.
module rc5_cipher
    import rc5_pkg::*;
#(
    parameter int W      = 16,
    parameter int ROUNDS = 12
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            mode,
    input  logic [2*W-1:0]                  p,
    output logic [2*W-1:0]                  c,
    output logic                            done,
    output logic                            busy,
    input  logic                            key_we,
    input  logic [$clog2(2*ROUNDS+2)-1:0]   key_addr,
    input  logic [W-1:0]                    key_data
);

    localparam int NKEYS = 2*ROUNDS + 2;
    localparam int RW    = $clog2(ROUNDS + 1);
    localparam int LG    = rot_width(W);
    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS);
    localparam logic [RW-1:0] ONE_RND  = RW'(1);

    if (!((W == RC5_W_SMALL) || (W == RC5_W_MID) || (W == RC5_W_LARGE)) ||
        (ROUNDS < RC5_ROUNDS_MIN) || (ROUNDS > RC5_ROUNDS_MAX)) begin : g_bad_cfg
        $error("rc5_cipher: unsupported W or ROUNDS");
    end

    rc5_state_e      state_q, state_d;
    logic [W-1:0]    a_q, b_q, a_d, b_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [2*W-1:0]  c_q;
    logic [W-1:0]    key_tab [NKEYS];

    // {rnd,0} and {rnd,1} are exactly key_addr wide, indexing S[2i] and S[2i+1].
    logic [W-1:0]    s_even, s_odd;
    logic [W-1:0]    r0_in, r0_out, r1_in, r1_out, half, other;
    logic [LG-1:0]   r0_amt;
    logic [W-1:0]    rnd_a, rnd_b;
    logic            dec_q, dec_start, last_rnd;

    assign s_even = key_tab[{rnd_q, 1'b0}];
    assign s_odd  = key_tab[{rnd_q, 1'b1}];

`ifdef RC5_DEC_EN
    assign dec_start = mode;

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            dec_q <= mode;
        end
    end

    // First half-round produces the new A (encrypt) or new B (decrypt); the second
    // half-round consumes it in the same cycle.
    assign r0_in  = dec_q ? (b_q - s_odd) : (a_q ^ b_q);
    assign r0_amt = dec_q ? a_q[LG-1:0] : b_q[LG-1:0];
    assign half   = dec_q ? (r0_out ^ a_q) : (r0_out + s_even);
    assign r1_in  = dec_q ? (a_q - s_even) : (b_q ^ half);
    assign other  = dec_q ? (r1_out ^ half) : (r1_out + s_odd);
    assign rnd_a  = dec_q ? other : half;
    assign rnd_b  = dec_q ? half : other;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign dec_start   = 1'b0;
    assign dec_q       = 1'b0;

    assign r0_in  = a_q ^ b_q;
    assign r0_amt = b_q[LG-1:0];
    assign half   = r0_out + s_even;
    assign r1_in  = b_q ^ half;
    assign other  = r1_out + s_odd;
    assign rnd_a  = half;
    assign rnd_b  = other;
`endif

    rc5_rotl #(.W(W)) u_rot0 (
        .x   (r0_in),
        .amt (r0_amt),
        .dir (dec_q),
        .y   (r0_out)
    );

    rc5_rotl #(.W(W)) u_rot1 (
        .x   (r1_in),
        .amt (half[LG-1:0]),
        .dir (dec_q),
        .y   (r1_out)
    );

    // Encrypt counts rounds up from 1, decrypt counts down from ROUNDS.
    assign last_rnd = dec_q ? (rnd_q == ONE_RND) : (rnd_q == LAST_RND);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = dec_start ? ROUND : PRE;
            PRE:     state_d = ROUND;
            ROUND:   if (last_rnd) state_d = dec_q ? POST : DONE;
            POST:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == PRE) || (state_q == ROUND) || (state_q == POST);
        done = (state_q == DONE);
    end

    assign c = c_q;

    // Datapath next values
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        rnd_d = rnd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = p[W-1:0];
                    b_d   = p[2*W-1:W];
                    rnd_d = dec_start ? LAST_RND : ONE_RND;
                end
            end
            PRE: begin
                a_d = a_q + key_tab[0];
                b_d = b_q + key_tab[1];
            end
            ROUND: begin
                a_d   = rnd_a;
                b_d   = rnd_b;
                rnd_d = dec_q ? (rnd_q - ONE_RND) : (rnd_q + ONE_RND);
            end
`ifdef RC5_DEC_EN
            POST: begin
                a_d = a_q - key_tab[0];
                b_d = b_q - key_tab[1];
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers; c is captured on entry to DONE so it is valid with done.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            rnd_q <= '0;
            c_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            rnd_q <= rnd_d;
            if (state_d == DONE) begin
                c_q <= {b_d, a_d};
            end
        end
    end

    // Round-key table survives reset; reset only blocks a coincident write.
    always_ff @(posedge clock) begin
        if (!reset && key_we && !busy && (int'(key_addr) < NKEYS)) begin
            key_tab[key_addr] <= key_data;
        end
    end

endmodule

// File: doc/rc5_cipher.md
RC5_CIPHER -- requirements
Module: rc5_cipher

Interface
REQ-001 SHALL have parameter W, default 16: word width in bits, legal values 8, 16 and 32.
REQ-002 SHALL have parameter ROUNDS, default 12: round count, legal range 1..20.
REQ-003 SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation, sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled together with start.
REQ-007 SHALL have port p, input, 2W bits: input block, with A = p[W-1:0] and B = p[2W-1:W].
REQ-008 SHALL have port c, output, 2W bits: result block {B,A}.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking c as valid.
REQ-010 SHALL have port busy, output, 1 bit: high from the accepting edge until done rises.
REQ-011 SHALL have port key_we, input, 1 bit: write enable for the round-key table.
REQ-012 SHALL have port key_addr, input, $clog2(2*ROUNDS+2) bits: round-key index.
REQ-013 SHALL have port key_data, input, W bits: round-key word S[key_addr].

Function
REQ-014 SHALL hold round keys S[0..2*ROUNDS+1] in an internal register table written by key_we.
REQ-015 SHALL ignore key writes while busy=1, and SHALL ignore writes with key_addr > 2*ROUNDS+1.
REQ-016 SHALL use FSM states IDLE, PRE, ROUND, POST and DONE.
REQ-017 SHALL, in IDLE with start=1, latch A, B and mode, assert busy, and move to PRE (encrypt) or ROUND (decrypt).
REQ-018 SHALL, in PRE, compute A = A+S[0] and B = B+S[1] mod 2^W, then move to ROUND.
REQ-019 SHALL, for each encrypt round i = 1..ROUNDS, compute A = ((A^B) <<< B[lg W-1:0]) + S[2i] and then B = ((B^A) <<< A[lg W-1:0]) + S[2i+1] using the new A, one round per cycle.
REQ-020 SHALL, for each decrypt round i = ROUNDS down to 1, compute B = ((B-S[2i+1]) >>> A[lg W-1:0]) ^ A and then A = ((A-S[2i]) >>> B[lg W-1:0]) ^ B using the new B, one round per cycle.
REQ-021 SHALL, in POST (decrypt only), compute B = B-S[1] and A = A-S[0], then move to DONE.
REQ-022 SHALL move from ROUND to DONE (encrypt) or POST (decrypt) after the last round.
REQ-023 SHALL, in DONE, drive done=1 and busy=0, update c to {B,A}, and return to IDLE on the next edge.
REQ-024 SHALL have a latency of exactly ROUNDS+2 cycles from the start-sampling edge to done=1, identical for both modes.
REQ-025 SHALL hold c stable from DONE until the next DONE.
REQ-026 SHALL ignore start and mode while busy=1 or in DONE.
REQ-027 SHALL, when key_we and an accepted start coincide in IDLE, apply the write, and the new key SHALL be used by the operation.
REQ-028 SHALL treat all arithmetic as modulo 2^W, with rotate amounts taken from the low $clog2(W) bits only.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, go to IDLE with c=0, done=0 and busy=0, clearing A, B and the round counter.
REQ-030 SHALL, when reset occurs mid-operation, abort the operation with no done pulse.
REQ-031 SHALL NOT clear the round-key table on reset.
REQ-032 SHALL take priority for reset over start and key_we.

Configuration
REQ-033 SHALL compile the decrypt path (POST state, subtract/right-rotate datapath, mode input use) only when RC5_DEC_EN is defined.
REQ-034 SHALL, when RC5_DEC_EN is undefined, keep the mode port but ignore it, always encrypt, and keep the same latency.

Structure
REQ-035 SHALL place the FSM state enum, the legal-W check constants and a rotate-amount width function in package rc5_pkg.
REQ-036 SHALL implement the variable left/right rotate in sub-module rc5_rotl, parameterised by W with a direction input, instantiated twice in the round datapath.
REQ-037 SHALL implement the FSM, round counter, key table and datapath registers in rc5_cipher.

Verification
REQ-038 W=16, ROUNDS=1, all keys 0, encrypt p=0x00000000 -> c=0x00000000 with done exactly 3 cycles after start.
REQ-039 W=16, ROUNDS=1, all keys 0, encrypt p=0x00000001 -> c=0x00020001; with RC5_DEC_EN, decrypt p=0x00020001 -> c=0x00000001.
REQ-040 W=32, ROUNDS=12, keys from the bench key-expansion model of an all-zero 16-byte key, encrypt p=0x0000000000000000 -> c=0x6D8F4B15EEDBA521; decrypt of that value -> 0.
REQ-041 Reset asserted during cycle 2 of a ROUNDS=12 operation -> no done pulse, busy=0, c=0; a following operation completes correctly without reloading keys.
REQ-042 start and key_we pulsed while busy -> both ignored, result unchanged; an out-of-range key_addr write in IDLE -> table unchanged.
